token_bucket_arbiter: RTL and testbench
=======================================

Name: token_bucket_arbiter

Overview:
Shares one token pool (an up/down delta counter with saturation) between NumReq requesters. Each request spends a variable number of tokens.
- Tokens are refilled periodically and can also be returned by downstream credit paths.
- Round-robin arbitration picks at most one requester per cycle.
- Sits in front of a shared bandwidth-limited resource (bus port, DMA engine) as a rate limiter/scheduler.

Parameters:
NumReq, 4, number of requesters (>=2)
Width, 8, token counter / cost / refill / capacity width
PeriodWidth, 16, refill period counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
cfg_en_i  in  1  enable arbitration and refill
cfg_period_i  in  PeriodWidth  cycles between refills (0 treated as 1)
cfg_refill_i  in  Width  tokens added per refill tick
cfg_capacity_i  in  Width  bucket ceiling
req_valid_i  in  NumReq  request valid per requester
req_cost_i  in  NumReq*Width  packed cost; requester i at [i*Width +: Width]
req_ready_o  out  NumReq  one-hot-or-zero grant; transfer when valid&ready
ret_valid_i  in  1  token return strobe
ret_tokens_i  in  Width  tokens returned
tokens_o  out  Width  current token count (registered)
tick_o  out  1  refill tick this cycle
cost_err_o  out  1  current candidate's cost exceeds cfg_capacity_i

Behaviour:
- Reset (rst_i high at clock edge): tokens_q=0, period_cnt=0, rr_ptr=0. Registered outputs read 0 in the following cycle. Combinational outputs (req_ready_o, tick_o, cost_err_o) are 0 while rst_i is high. Reset mid-grant aborts it; no token change takes effect.
- Requester rule: once req_valid_i[i] is high, it holds, with a stable cost, until granted. The bench asserts this.
- Candidate selection: first i with req_valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NumReq.
- Grant: req_ready_o[cand]=1 combinationally iff cfg_en_i & tokens_q >= cost[cand]. No skip-ahead: if the candidate cannot afford its cost, nothing is granted and rr_ptr holds. This makes expensive requests wait for tokens rather than starve.
- On a grant, rr_ptr <= (cand+1) mod NumReq, and consume = cost[cand]; otherwise consume = 0.
- Cost 0: granted whenever selected and enabled; consumes nothing.
- cost_err_o = candidate exists & cost[cand] > cfg_capacity_i. This is a deadlock indicator; the block takes no other action.
- Refill period counter, when cfg_en_i=1:
  - tick_o = (period_cnt == max(cfg_period_i,1)-1).
  - On tick, period_cnt <= 0; else period_cnt <= period_cnt+1.
  - If cfg_period_i is changed to a value below the current period_cnt, the counter wraps through its maximum value.
- cfg_en_i=0: no grants, tick_o=0, period_cnt <= 0. tokens_q keeps accepting returns and the capacity clamp.
- Token update (Width+2-bit arithmetic, single cycle):
  - sum = tokens_q - consume + (tick ? cfg_refill_i : 0) + (ret_valid_i ? ret_tokens_i : 0)
  - tokens_q <= min(sum, cfg_capacity_i)
  - sum can never be negative because consume <= tokens_q.
- Simultaneous grant, refill and return in one cycle: all three apply together. The affordability check uses pre-update tokens_q only; tokens arriving this cycle cannot fund this cycle's grant.
- cfg_capacity_i lowered below tokens_q: tokens_q clamps to the new ceiling at the next edge. Capacity 0 forces tokens_q to 0.
- Latency: a grant is visible in the same cycle as the request is presented when affordable. tokens_o reflects the grant one cycle later.

Test Plan:
- Reset then cfg_en=1, period=4, refill=3, capacity=10, no requests -> tick_o at cycles 3,7,11,15 after enable; tokens_o 3,6,9,10,10 (saturates).
- tokens=10, all 4 requesters valid with cost 2 -> grants 0,1,2,3,0 on consecutive cycles; tokens_o 8,6,4,2,0; req 1 then waits with ready=0.
- tokens=5, rr_ptr at requester 1 (cost 7), requester 2 valid (cost 1), refill 3 every 4 cycles -> no grant to 2 while 1 waits; 1 granted once tokens>=7, then 2 granted next cycle.
- tokens=4, grant of cost 4 + tick(refill 3) + return 5, capacity 10 in the same cycle -> tokens_o=8 next cycle.
- Requester cost 12, capacity 10 -> cost_err_o=1 while it is the candidate, no grant ever; lowering capacity from 10 to 6 while tokens=9 -> tokens_o=6 next cycle.
- rst_i asserted for one cycle mid-stream with requests valid -> req_ready_o=0 that cycle; tokens_o=0, rr_ptr=0 afterwards; first grant goes to the lowest valid index once affordable.

Source files
------------

// File: rtl/token_bucket_arbiter.sv
// Round-robin arbiter gated by a shared token bucket: each grant spends the
// winner's cost, and tokens come back from a periodic refill and a return port.
module token_bucket_arbiter #(
  parameter int NumReq      = 4,
  parameter int Width       = 8,
  parameter int PeriodWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_en_i,
  input  logic [PeriodWidth-1:0]    cfg_period_i,
  input  logic [Width-1:0]          cfg_refill_i,
  input  logic [Width-1:0]          cfg_capacity_i,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq*Width-1:0]   req_cost_i,
  output logic [NumReq-1:0]         req_ready_o,
  input  logic                      ret_valid_i,
  input  logic [Width-1:0]          ret_tokens_i,
  output logic [Width-1:0]          tokens_o,
  output logic                      tick_o,
  output logic                      cost_err_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  // Two spare bits hold tokens + refill + return without overflow.
  localparam int SumW = Width + 2;

  logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [Width-1:0]       tokens_q, tokens_d;
  logic [PeriodWidth-1:0] period_cnt_q, period_cnt_d;

  logic                   cand_found;
  logic [PtrW-1:0]        cand_idx;
  logic [PtrW-1:0]        scan_idx;
  logic [Width-1:0]       cand_cost;
  logic                   grant;
  logic                   tick;
  logic [PeriodWidth-1:0] period_last;
  logic [Width-1:0]       consume;
  logic [SumW-1:0]        sum;

  function automatic logic [PtrW-1:0] rr_index(input logic [PtrW-1:0] base, input int offset);
    int wrapped;
    wrapped = (int'(base) + offset) % NumReq;
    return PtrW'(wrapped);
  endfunction

  // Candidate is the first valid requester at or after rr_ptr; no skip-ahead.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_cost  = '0;
    scan_idx   = '0;
    for (int k = 0; k < NumReq; k++) begin
      scan_idx = rr_index(rr_ptr_q, k);
      if (!cand_found && req_valid_i[scan_idx]) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx;
        cand_cost  = req_cost_i[scan_idx*Width +: Width];
      end
    end
  end

  // Period 0 behaves like period 1: a tick every enabled cycle.
  assign period_last = (cfg_period_i == '0) ? '0 : cfg_period_i - 1'b1;
  assign tick        = !rst_i && cfg_en_i && (period_cnt_q == period_last);
  assign grant       = !rst_i && cfg_en_i && cand_found && (tokens_q >= cand_cost);
  assign consume     = grant ? cand_cost : '0;

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = grant && (cand_idx == PtrW'(i));
    end
  end

  assign tick_o     = tick;
  assign cost_err_o = !rst_i && cand_found && (cand_cost > cfg_capacity_i);
  assign tokens_o   = tokens_q;

  // Affordability above used the pre-update count; arrivals only land here.
  always_comb begin
    sum = SumW'(tokens_q) - SumW'(consume);
    if (tick) begin
      sum = sum + SumW'(cfg_refill_i);
    end
    if (ret_valid_i) begin
      sum = sum + SumW'(ret_tokens_i);
    end
    tokens_d = (sum > SumW'(cfg_capacity_i)) ? cfg_capacity_i : sum[Width-1:0];
  end

  always_comb begin
    period_cnt_d = period_cnt_q + 1'b1;
    if (!cfg_en_i || tick) begin
      period_cnt_d = '0;
    end
    rr_ptr_d = grant ? rr_index(cand_idx, 1) : rr_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; the reset is synchronous and lives inside the clocked branch.
    if (rst_i) begin
      tokens_q     <= '0;
      period_cnt_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      tokens_q     <= tokens_d;
      period_cnt_q <= period_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_token_bucket_arbiter.sv
// Self-checking bench for token_bucket_arbiter: per-cycle expected outputs are
// queued as stimulus is driven and popped when the outputs are sampled.
module tb_token_bucket_arbiter;

  localparam int NumReq      = 4;
  localparam int Width       = 8;
  localparam int PeriodWidth = 16;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    cfg_en_i;
  logic [PeriodWidth-1:0]  cfg_period_i;
  logic [Width-1:0]        cfg_refill_i;
  logic [Width-1:0]        cfg_capacity_i;
  logic [NumReq-1:0]       req_valid_i;
  logic [NumReq*Width-1:0] req_cost_i;
  logic [NumReq-1:0]       req_ready_o;
  logic                    ret_valid_i;
  logic [Width-1:0]        ret_tokens_i;
  logic [Width-1:0]        tokens_o;
  logic                    tick_o;
  logic                    cost_err_o;

  token_bucket_arbiter #(
    .NumReq(NumReq), .Width(Width), .PeriodWidth(PeriodWidth)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_period_i(cfg_period_i),
    .cfg_refill_i(cfg_refill_i), .cfg_capacity_i(cfg_capacity_i),
    .req_valid_i(req_valid_i), .req_cost_i(req_cost_i), .req_ready_o(req_ready_o),
    .ret_valid_i(ret_valid_i), .ret_tokens_i(ret_tokens_i), .tokens_o(tokens_o),
    .tick_o(tick_o), .cost_err_o(cost_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] period;
    logic [7:0]  refill;
    logic [7:0]  cap;
    logic [3:0]  valid;
    logic [31:0] cost;
    logic        ret_v;
    logic [7:0]  ret;
  } stim_t;

  typedef struct {
    logic [3:0] ready;
    logic [7:0] tokens;
    logic       tick;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{rst: 1'b0, en: 1'b0, period: 16'd0, refill: 8'd0, cap: 8'd0,
          valid: 4'd0, cost: 32'd0, ret_v: 1'b0, ret: 8'd0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst_i          = s.rst;
    cfg_en_i       = s.en;
    cfg_period_i   = s.period;
    cfg_refill_i   = s.refill;
    cfg_capacity_i = s.cap;
    req_valid_i    = s.valid;
    req_cost_i     = s.cost;
    ret_valid_i    = s.ret_v;
    ret_tokens_i   = s.ret;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    stim_t s;
    s = idle_stim();
    s.rst = 1'b1;
    next_cycle();
    drive(s);
  endtask

  // A pending request must hold, with its cost, until granted (reset releases it).
  logic [3:0]  p_valid = '0;
  logic [3:0]  p_ready = '0;
  logic [31:0] p_cost  = '0;
  logic        p_rst   = 1'b1;
  always @(posedge clk_i) begin
    for (int i = 0; i < NumReq; i++) begin
      if (p_valid[i] && !p_ready[i] && !p_rst && !rst_i) begin
        checks++;
        if (!req_valid_i[i] || req_cost_i[i*Width +: Width] !== p_cost[i*Width +: Width]) begin
          errors++;
          $display("FAIL req_rule req%0d: valid=%b cost=%0d, required held valid with cost %0d",
                   i, req_valid_i[i], req_cost_i[i*Width +: Width], p_cost[i*Width +: Width]);
        end
      end
    end
    p_valid = req_valid_i;
    p_ready = req_ready_o;
    p_cost  = req_cost_i;
    p_rst   = rst_i;
  end

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    s = idle_stim();
    s.rst = 1'b1; s.en = 1'b1; s.period = 16'd1; s.cap = 8'd0;
    s.valid = 4'b0001; s.cost = 32'd5; s.ret_v = 1'b1; s.ret = 8'd7;
    drive(s);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      if (c == 2) drive(idle_stim());
      exp_q.push_back('{ready: 4'd0, tokens: 8'd0, tick: 1'b0, err: 1'b0});
      #1;
      e = exp_q.pop_front();
      checks += 4;
      if (req_ready_o !== e.ready) begin errors++; $display("FAIL reset c=%0d ready: got %b want %b", c, req_ready_o, e.ready); end
      if (tokens_o !== e.tokens)   begin errors++; $display("FAIL reset c=%0d tokens: got %0d want %0d", c, tokens_o, e.tokens); end
      if (tick_o !== e.tick)       begin errors++; $display("FAIL reset c=%0d tick: got %b want %b", c, tick_o, e.tick); end
      if (cost_err_o !== e.err)    begin errors++; $display("FAIL reset c=%0d cost_err: got %b want %b", c, cost_err_o, e.err); end
    end
  endtask

  task automatic test_refill();
    stim_t s;
    exp_t  e;
    int    filled;
    apply_reset();
    s = idle_stim();
    s.en = 1'b1; s.period = 16'd4; s.refill = 8'd3; s.cap = 8'd10;
    for (int c = 0; c <= 20; c++) begin
      next_cycle();
      drive(s);
      filled = (c / 4) * 3;
      if (filled > 10) filled = 10;
      exp_q.push_back('{ready: 4'd0, tokens: 8'(filled), tick: (c % 4 == 3), err: 1'b0});
      #1;
      e = exp_q.pop_front();
      checks += 4;
      if (req_ready_o !== e.ready) begin errors++; $display("FAIL refill c=%0d ready: got %b want %b", c, req_ready_o, e.ready); end
      if (tokens_o !== e.tokens)   begin errors++; $display("FAIL refill c=%0d tokens: got %0d want %0d", c, tokens_o, e.tokens); end
      if (tick_o !== e.tick)       begin errors++; $display("FAIL refill c=%0d tick: got %b want %b", c, tick_o, e.tick); end
      if (cost_err_o !== e.err)    begin errors++; $display("FAIL refill c=%0d cost_err: got %b want %b", c, cost_err_o, e.err); end
    end
  endtask

  task automatic test_round_robin();
    stim_t s;
    exp_t  e;
    int    rdy_t[7] = '{0, 1, 2, 4, 8, 1, 0};
    int    tok_t[7] = '{0, 10, 8, 6, 4, 2, 0};
    int    tck_t[7] = '{0, 0, 0, 0, 1, 0, 0};
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      s = idle_stim();
      s.cap = 8'd10;
      if (c == 0) begin
        s.ret_v = 1'b1; s.ret = 8'd10;
      end else begin
        s.en = 1'b1; s.period = 16'd4; s.valid = 4'b1111; s.cost = 32'h02020202;
      end
      drive(s);
      exp_q.push_back('{ready: 4'(rdy_t[c]), tokens: 8'(tok_t[c]), tick: 1'(tck_t[c]), err: 1'b0});
      #1;
      e = exp_q.pop_front();
      checks += 4;
      if (req_ready_o !== e.ready) begin errors++; $display("FAIL rr c=%0d ready: got %b want %b", c, req_ready_o, e.ready); end
      if (tokens_o !== e.tokens)   begin errors++; $display("FAIL rr c=%0d tokens: got %0d want %0d", c, tokens_o, e.tokens); end
      if (tick_o !== e.tick)       begin errors++; $display("FAIL rr c=%0d tick: got %b want %b", c, tick_o, e.tick); end
      if (cost_err_o !== e.err)    begin errors++; $display("FAIL rr c=%0d cost_err: got %b want %b", c, cost_err_o, e.err); end
    end
  endtask

  task automatic test_no_skip_ahead();
    stim_t s;
    exp_t  e;
    int    rdy_t[7] = '{1, 0, 0, 0, 2, 4, 0};
    int    tok_t[7] = '{0, 5, 5, 5, 8, 1, 0};
    int    tck_t[7] = '{0, 0, 0, 1, 0, 0, 0};
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      s = idle_stim();
      s.en = 1'b1; s.period = 16'd4; s.refill = 8'd3; s.cap = 8'd10;
      s.cost = 32'h00010700;
      case (c)
        0:       begin s.valid = 4'b0001; s.cost = 32'd0; s.ret_v = 1'b1; s.ret = 8'd5; end
        5:       s.valid = 4'b0100;
        6:       s.valid = 4'b0000;
        default: s.valid = 4'b0110;
      endcase
      drive(s);
      exp_q.push_back('{ready: 4'(rdy_t[c]), tokens: 8'(tok_t[c]), tick: 1'(tck_t[c]), err: 1'b0});
      #1;
      e = exp_q.pop_front();
      checks += 4;
      if (req_ready_o !== e.ready) begin errors++; $display("FAIL noskip c=%0d ready: got %b want %b", c, req_ready_o, e.ready); end
      if (tokens_o !== e.tokens)   begin errors++; $display("FAIL noskip c=%0d tokens: got %0d want %0d", c, tokens_o, e.tokens); end
      if (tick_o !== e.tick)       begin errors++; $display("FAIL noskip c=%0d tick: got %b want %b", c, tick_o, e.tick); end
      if (cost_err_o !== e.err)    begin errors++; $display("FAIL noskip c=%0d cost_err: got %b want %b", c, cost_err_o, e.err); end
    end
  endtask

  task automatic test_simultaneous();
    stim_t s;
    exp_t  e;
    int    rdy_t[4] = '{0, 1, 2, 0};
    int    tok_t[4] = '{0, 4, 8, 10};
    int    tck_t[4] = '{0, 1, 1, 0};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      s = idle_stim();
      s.cap = 8'd10;
      case (c)
        0: begin s.valid = 4'b0010; s.ret_v = 1'b1; s.ret = 8'd4; end
        1: begin
          s.en = 1'b1; s.period = 16'd1; s.refill = 8'd3;
          s.valid = 4'b0011; s.cost = 32'd4; s.ret_v = 1'b1; s.ret = 8'd5;
        end
        2: begin s.en = 1'b1; s.period = 16'd1; s.refill = 8'd3; s.valid = 4'b0010; s.cost = 32'd4; end
        default: ;
      endcase
      drive(s);
      exp_q.push_back('{ready: 4'(rdy_t[c]), tokens: 8'(tok_t[c]), tick: 1'(tck_t[c]), err: 1'b0});
      #1;
      e = exp_q.pop_front();
      checks += 4;
      if (req_ready_o !== e.ready) begin errors++; $display("FAIL simul c=%0d ready: got %b want %b", c, req_ready_o, e.ready); end
      if (tokens_o !== e.tokens)   begin errors++; $display("FAIL simul c=%0d tokens: got %0d want %0d", c, tokens_o, e.tokens); end
      if (tick_o !== e.tick)       begin errors++; $display("FAIL simul c=%0d tick: got %b want %b", c, tick_o, e.tick); end
      if (cost_err_o !== e.err)    begin errors++; $display("FAIL simul c=%0d cost_err: got %b want %b", c, cost_err_o, e.err); end
    end
  endtask

  task automatic test_cost_err_capacity();
    stim_t s;
    exp_t  e;
    int    tok_t[8] = '{0, 9, 9, 9, 9, 6, 6, 0};
    int    tck_t[8] = '{0, 0, 1, 0, 1, 0, 1, 0};
    int    cap_t[8] = '{10, 10, 10, 10, 6, 6, 0, 0};
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      s = idle_stim();
      s.cap = 8'(cap_t[c]);
      s.valid = 4'b0011; s.cost = 32'h0000010C;
      if (c == 0) begin
        s.ret_v = 1'b1; s.ret = 8'd9;
      end else begin
        s.en = 1'b1; s.period = 16'd2;
      end
      drive(s);
      exp_q.push_back('{ready: 4'd0, tokens: 8'(tok_t[c]), tick: 1'(tck_t[c]), err: 1'b1});
      #1;
      e = exp_q.pop_front();
      checks += 4;
      if (req_ready_o !== e.ready) begin errors++; $display("FAIL costerr c=%0d ready: got %b want %b", c, req_ready_o, e.ready); end
      if (tokens_o !== e.tokens)   begin errors++; $display("FAIL costerr c=%0d tokens: got %0d want %0d", c, tokens_o, e.tokens); end
      if (tick_o !== e.tick)       begin errors++; $display("FAIL costerr c=%0d tick: got %b want %b", c, tick_o, e.tick); end
      if (cost_err_o !== e.err)    begin errors++; $display("FAIL costerr c=%0d cost_err: got %b want %b", c, cost_err_o, e.err); end
    end
  endtask

  task automatic test_reset_mid_stream();
    stim_t s;
    exp_t  e;
    int    rdy_t[6] = '{2, 4, 0, 0, 4, 0};
    int    tok_t[6] = '{0, 10, 7, 0, 3, 0};
    int    tck_t[6] = '{1, 1, 0, 1, 1, 1};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      s = idle_stim();
      s.en = 1'b1; s.period = 16'd1; s.cap = 8'd10;
      s.valid = 4'b1100; s.cost = 32'h03030000;
      case (c)
        0: begin s.valid = 4'b0010; s.cost = 32'd0; s.ret_v = 1'b1; s.ret = 8'd10; end
        2: s.rst = 1'b1;
        3: begin s.ret_v = 1'b1; s.ret = 8'd3; end
        5: s.valid = 4'b1000;
        default: ;
      endcase
      drive(s);
      exp_q.push_back('{ready: 4'(rdy_t[c]), tokens: 8'(tok_t[c]), tick: 1'(tck_t[c]), err: 1'b0});
      #1;
      e = exp_q.pop_front();
      checks += 4;
      if (req_ready_o !== e.ready) begin errors++; $display("FAIL midrst c=%0d ready: got %b want %b", c, req_ready_o, e.ready); end
      if (tokens_o !== e.tokens)   begin errors++; $display("FAIL midrst c=%0d tokens: got %0d want %0d", c, tokens_o, e.tokens); end
      if (tick_o !== e.tick)       begin errors++; $display("FAIL midrst c=%0d tick: got %b want %b", c, tick_o, e.tick); end
      if (cost_err_o !== e.err)    begin errors++; $display("FAIL midrst c=%0d cost_err: got %b want %b", c, cost_err_o, e.err); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_refill();
    test_round_robin();
    test_no_skip_ahead();
    test_simultaneous();
    test_cost_err_capacity();
    test_reset_mid_stream();
    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
